// File: rtl/albacore_uart_rx.sv
// 8N1 UART receiver with a show-ahead receive FIFO and sticky error flags.
// Define ALBACORE_UART_RX_PARITY_EN to expect one even-parity bit after bit 7.
module albacore_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_serial,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef ALBACORE_UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, RECOVER
  } state_t;

  state_t        state;
  logic          rx_meta, rx_s;
  logic [15:0]   cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tick_bit, tick_half, stop_ev, frame_ev, par_ev, par_ok;
  logic          push, pop, full, wr, ov_ev;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Synchronizer: idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

`ifdef ALBACORE_UART_RX_PARITY_EN
  logic par_bad;
  assign par_ok = !par_bad;
  assign par_ev = (state == PARITY) && tick_bit && (rx_s != (^shift));
`else
  assign par_ok = 1'b1;
  assign par_ev = 1'b0;
`endif

  always_comb begin
    tick_bit  = (cnt == BIT_LAST);
    tick_half = (cnt == HALF_LAST);
    stop_ev   = (state == STOP) && tick_bit;
    frame_ev  = stop_ev && !rx_s;
    push      = stop_ev && rx_s && par_ok;
    full      = (rx_count == FULL_CNT);
    pop       = rd_en && (rx_count != '0);
    wr        = push && (!full || pop);
    ov_ev     = push && full && !pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
`ifdef ALBACORE_UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      cnt <= cnt + 16'd1;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: if (tick_half) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rx_s ? IDLE : DATA;
        end
        DATA: if (tick_bit) begin
          cnt     <= '0;
          bit_idx <= bit_idx + 3'd1;
`ifdef ALBACORE_UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef ALBACORE_UART_RX_PARITY_EN
        PARITY: if (tick_bit) begin
          cnt     <= '0;
          par_bad <= (rx_s != (^shift));
          state   <= STOP;
        end
`endif
        STOP: if (tick_bit) begin
          cnt   <= '0;
          state <= rx_s ? IDLE : RECOVER;
        end
        RECOVER: begin
          // A held-low break must not be mistaken for a new start bit.
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == DATA && tick_bit) shift <= {rx_s, shift[7:1]};
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= shift;
  end

  // Simultaneous push and pop on a full FIFO overwrites the slot being popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !pop)      rx_count <= rx_count + (AW + 1)'(1);
      else if (pop && !wr) rx_count <= rx_count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (clr_err) begin
        overrun    <= 1'b0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      if (ov_ev)    overrun    <= 1'b1;
      if (frame_ev) frame_err  <= 1'b1;
      if (par_ev)   parity_err <= 1'b1;
    end
  end

  assign rx_valid = (rx_count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule
